// File: rtl/vram_scan_arbiter_if.sv
// GPU access port and pixel stream port of the VRAM scan arbiter.
// The master side is the GPU plus the pixel consumer; the slave side is the arbiter.
interface vram_scan_arbiter_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
);
  logic                 gpu_req;
  logic                 gpu_we;
  logic [X_W+Y_W-1:0]   gpu_addr;
  logic [15:0]          gpu_wdata;
  logic                 gpu_gnt;
  logic [15:0]          gpu_rdata;
  logic                 px_valid;
  logic                 px_ready;
  logic [23:0]          px_data;
  logic [X_W-1:0]       px_x;

  modport master (
    output gpu_req, gpu_we, gpu_addr, gpu_wdata, px_ready,
    input  gpu_gnt, gpu_rdata, px_valid, px_data, px_x
  );

  modport slave (
    input  gpu_req, gpu_we, gpu_addr, gpu_wdata, px_ready,
    output gpu_gnt, gpu_rdata, px_valid, px_data, px_x
  );
endinterface

// File: rtl/vram_scan_arbiter.sv
// Shares one async VRAM SRAM between GPU accesses and a scanline prefetcher that
// scales a source span into a pixel FIFO, with a guard against GPU starvation.
module vram_scan_arbiter #(
  parameter int SCREEN_W    = 320,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_VGA_RUN = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_req,
  input  logic [Y_W-1:0]        line_y,
  input  logic [X_W-1:0]        x_tl,
  input  logic [X_W-1:0]        dis_w,
  output logic                  busy,
  output logic                  line_done,
  output logic                  line_overrun,
  vram_scan_arbiter_if.slave    bus,
  input  logic [15:0]           sram_dq_in,
  output logic [15:0]           sram_dq_out,
  output logic [19:0]           sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);
  localparam int ACC_W = X_W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int RUN_W = $clog2(MAX_VGA_RUN + 1);
  localparam logic [ACC_W-1:0] SW1      = ACC_W'(SCREEN_W);
  localparam logic [ACC_W-1:0] SW2      = ACC_W'(2 * SCREEN_W);
  localparam logic [X_W:0]     DIS_MAX  = (X_W + 1)'(2 * SCREEN_W - 1);
  localparam logic [X_W-1:0]   LAST_X   = X_W'(SCREEN_W - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_VGA_RUN);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t             r_state, w_stateNext;
  logic [Y_W-1:0]     r_row;
  logic [X_W-1:0]     r_srcX;
  logic [ACC_W-1:0]   r_acc;
  logic [X_W-1:0]     r_disW;
  logic [X_W-1:0]     r_fetchCnt;
  logic [RUN_W-1:0]   r_runCnt;
  logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
  logic [PTR_W:0]     r_count;
  logic [23:0]        r_fifoData [FIFO_DEPTH];
  logic [X_W-1:0]     r_fifoX    [FIFO_DEPTH];

  logic               w_valid, w_pop, w_slot, w_guard, w_fetchGnt, w_gpuGnt;
  logic [ACC_W-1:0]   w_accSum;

  function automatic logic [23:0] expand(input logic [14:0] w);
    return {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2]};
  endfunction

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid & bus.px_ready;
  assign w_slot     = (r_state == S_FETCH) && ((r_count != FULL_CNT) || w_pop);
  assign w_guard    = (r_runCnt == RUN_MAX) && bus.gpu_req;
  assign w_fetchGnt = w_slot && !w_guard;
  assign w_gpuGnt   = bus.gpu_req && !w_fetchGnt;
  assign w_accSum   = r_acc + {2'b00, r_disW};

  assign busy         = (r_state != S_IDLE);
  assign bus.gpu_gnt  = w_gpuGnt;
  assign bus.px_valid = w_valid;
  assign bus.px_data  = w_valid ? r_fifoData[r_rdPtr] : 24'h0;
  assign bus.px_x     = w_valid ? r_fifoX[r_rdPtr] : '0;
  assign sram_ce_n    = 1'b0;
  assign sram_lb_n    = 1'b0;
  assign sram_ub_n    = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext  = r_state;
    line_done    = 1'b0;
    line_overrun = 1'b0;
    case (r_state)
      S_IDLE: if (line_req) w_stateNext = S_FETCH;
      S_FETCH: begin
        line_overrun = line_req;
        if (w_fetchGnt && (r_fetchCnt == LAST_X)) w_stateNext = S_DRAIN;
      end
      S_DRAIN: begin
        line_overrun = line_req;
        if (w_pop && (r_fifoX[r_rdPtr] == LAST_X)) begin
          line_done   = 1'b1;
          w_stateNext = S_IDLE;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Incremental scaler: acc stays below SCREEN_W, and dis_w < 2*SCREEN_W, so src_x advances 0..2 per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_srcX     <= '0;
      r_acc      <= '0;
      r_disW     <= '0;
      r_fetchCnt <= '0;
    end else if ((r_state == S_IDLE) && line_req) begin
      r_row      <= line_y;
      r_srcX     <= x_tl;
      r_acc      <= '0;
      r_fetchCnt <= '0;
      if ({1'b0, dis_w} > DIS_MAX) r_disW <= DIS_MAX[X_W-1:0];
      else if (dis_w == '0)         r_disW <= X_W'(1);
      else                          r_disW <= dis_w;
    end else if (w_fetchGnt) begin
      r_fetchCnt <= r_fetchCnt + X_W'(1);
      if (w_accSum >= SW2) begin
        r_srcX <= r_srcX + X_W'(2);
        r_acc  <= w_accSum - SW2;
      end else if (w_accSum >= SW1) begin
        r_srcX <= r_srcX + X_W'(1);
        r_acc  <= w_accSum - SW1;
      end else begin
        r_acc  <= w_accSum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_runCnt <= '0;
    else if (!bus.gpu_req || w_gpuGnt)   r_runCnt <= '0;
    else if (w_fetchGnt && (r_runCnt != RUN_MAX)) r_runCnt <= r_runCnt + RUN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_fetchGnt) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)      r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_fetchGnt && !w_pop)      r_count <= r_count + (PTR_W + 1)'(1);
      else if (!w_fetchGnt && w_pop) r_count <= r_count - (PTR_W + 1)'(1);
    end
  end

  // Storage needs no reset: the head is masked by the count until written.
  always_ff @(posedge clk) begin
    if (w_fetchGnt) begin
      r_fifoData[r_wrPtr] <= expand(sram_dq_in[14:0]);
      r_fifoX[r_wrPtr]    <= r_fetchCnt;
    end
  end

  always_comb begin
    sram_addr     = 20'h0;
    sram_dq_out   = 16'h0;
    sram_oe_n     = 1'b1;
    sram_we_n     = 1'b1;
    bus.gpu_rdata = 16'h0;
    if (w_fetchGnt) begin
      sram_addr = 20'({r_row, r_srcX});
      sram_oe_n = 1'b0;
    end else if (w_gpuGnt) begin
      sram_addr = 20'(bus.gpu_addr);
      if (bus.gpu_we) begin
        sram_we_n   = 1'b0;
        sram_dq_out = bus.gpu_wdata;
      end else begin
        sram_oe_n     = 1'b0;
        bus.gpu_rdata = sram_dq_in;
      end
    end
  end
endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed self-checking bench for vram_scan_arbiter with a behavioural SRAM
// whose word content is a fixed function of the address.
module tb_vram_scan_arbiter;
  localparam int SW    = 320;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_req;
  logic [8:0]  line_y;
  logic [9:0]  x_tl, dis_w;
  logic        busy, line_done, line_overrun;
  logic [15:0] sram_dq_in, sram_dq_out;
  logic [19:0] sram_addr;
  logic        sram_ce_n, sram_lb_n, sram_ub_n, sram_oe_n, sram_we_n;
  logic        forceEn;
  logic [15:0] forceWord;
  logic [19:0] expAddr [SW];
  logic [19:0] lastAddr;
  logic [9:0]  seenX [4];
  int          tests = 0;
  int          fails = 0;

  vram_scan_arbiter_if #(.X_W(10), .Y_W(9)) bus ();

  vram_scan_arbiter dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_y(line_y), .x_tl(x_tl),
    .dis_w(dis_w), .busy(busy), .line_done(line_done), .line_overrun(line_overrun),
    .bus(bus), .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] w);
    return {w[14:10], w[14:12], w[9:5], w[9:7], w[4:0], w[4:2]};
  endfunction

  always_comb sram_dq_in = forceEn ? forceWord : memWord(sram_addr);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic buildExp(input int y, input int x, input int w);
    int wEff;
    wEff = (w > 2 * SW - 1) ? 2 * SW - 1 : ((w == 0) ? 1 : w);
    for (int i = 0; i < SW; i++)
      expAddr[i] = 20'((y << 10) + ((x + (i * wEff) / SW) % 1024));
  endtask

  // Called #1 after a clock edge; returns #1 into the first busy cycle.
  task automatic applyStimulus(input logic [8:0] y, input logic [9:0] x, input logic [9:0] w);
    buildExp(int'(y), int'(x), int'(w));
    line_y = y; x_tl = x; dis_w = w; line_req = 1'b1;
    @(posedge clk); #1;
    line_req = 1'b0;
  endtask

  task automatic runLine(input int overrunAt);
    for (int c = 1; c <= SW + 1; c++) begin
      line_req = (c == overrunAt);
      if (c == overrunAt) begin line_y = 9'h1FF; x_tl = 10'd50; dis_w = 10'd100; end
      @(negedge clk);
      checkOutput("line_busy", 32'(busy), 32'd1);
      if (c <= SW) begin
        checkOutput("fetch_oe", 32'(sram_oe_n), 32'd0);
        checkOutput("fetch_addr", 32'(sram_addr), 32'(expAddr[c-1]));
        if (c <= 4) seenX[c-1] = sram_addr[9:0];
        if (c == SW) lastAddr = sram_addr;
      end
      if (c >= 2) begin
        checkOutput("px_valid", 32'(bus.px_valid), 32'd1);
        checkOutput("px_x", 32'(bus.px_x), 32'(c - 2));
        checkOutput("px_data", 32'(bus.px_data), 32'(expand(memWord(expAddr[c-2]))));
      end
      checkOutput("line_done", 32'(line_done), 32'(c == SW + 1));
      checkOutput("line_overrun", 32'(line_overrun), 32'(c == overrunAt));
      @(posedge clk); #1;
    end
    line_req = 1'b0;
    @(negedge clk);
    checkOutput("after_busy", 32'(busy), 32'd0);
    checkOutput("after_valid", 32'(bus.px_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fetches, idx;
    logic done;
    rst_n = 1'b0; line_req = 1'b0; line_y = '0; x_tl = '0; dis_w = '0;
    forceEn = 1'b0; forceWord = '0;
    bus.gpu_req = 1'b0; bus.gpu_we = 1'b0; bus.gpu_addr = '0; bus.gpu_wdata = '0;
    bus.px_ready = 1'b0;
    #3;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(bus.px_valid), 32'd0);
    checkOutput("rst_px_data", 32'(bus.px_data), 32'd0);
    checkOutput("rst_px_x", 32'(bus.px_x), 32'd0);
    checkOutput("rst_oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("rst_addr", 32'(sram_addr), 32'd0);
    checkOutput("rst_dq_out", 32'(sram_dq_out), 32'd0);
    checkOutput("rst_gnt", 32'(bus.gpu_gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle GPU read is granted directly.
    bus.gpu_req = 1'b1; bus.gpu_addr = 19'h00010;
    @(negedge clk);
    checkOutput("idle_gnt", 32'(bus.gpu_gnt), 32'd1);
    checkOutput("idle_rdata", 32'(bus.gpu_rdata), 32'(memWord(20'h00010)));
    @(posedge clk); #1;
    bus.gpu_req = 1'b0;

    // Unscaled line.
    bus.px_ready = 1'b1;
    applyStimulus(9'd5, 10'd0, 10'd320);
    runLine(0);
    checkOutput("l1_last_addr", 32'(lastAddr), 32'(5 * 1024 + 319));

    // Half-rate scaling.
    applyStimulus(9'd7, 10'd100, 10'd160);
    runLine(0);
    checkOutput("l2_x0", 32'(seenX[0]), 32'd100);
    checkOutput("l2_x1", 32'(seenX[1]), 32'd100);
    checkOutput("l2_x2", 32'(seenX[2]), 32'd101);
    checkOutput("l2_x3", 32'(seenX[3]), 32'd101);
    checkOutput("l2_last_x", 32'(lastAddr[9:0]), 32'd259);

    // Maximum span wraps within the row: 1000 + floor(319*639/320) = 1637 -> 613.
    applyStimulus(9'd3, 10'd1000, 10'd639);
    runLine(0);
    checkOutput("l3_last_x", 32'(lastAddr[9:0]), 32'd613);
    checkOutput("l3_last_y", 32'(lastAddr[18:10]), 32'd3);

    // Over-wide and zero spans are clamped.
    applyStimulus(9'd8, 10'd5, 10'd1023);
    runLine(0);
    applyStimulus(9'd8, 10'd40, 10'd0);
    runLine(0);
    checkOutput("l5_last_x", 32'(lastAddr[9:0]), 32'd40);

    // Stalled consumer: FIFO fills, GPU still served, then resumes in order.
    bus.px_ready = 1'b0;
    applyStimulus(9'd1, 10'd0, 10'd320);
    fetches = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!sram_oe_n) fetches++;
      @(posedge clk); #1;
    end
    checkOutput("stall_fetches", 32'(fetches), 32'(DEPTH));
    checkOutput("stall_head_x", 32'(bus.px_x), 32'd0);
    bus.gpu_req = 1'b1; bus.gpu_we = 1'b0; bus.gpu_addr = 19'h00ABC;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("stall_gnt", 32'(bus.gpu_gnt), 32'd1);
      checkOutput("stall_addr", 32'(sram_addr), 32'h00ABC);
      checkOutput("stall_rdata", 32'(bus.gpu_rdata), 32'(memWord(20'h00ABC)));
      @(posedge clk); #1;
    end
    bus.gpu_req = 1'b0; bus.px_ready = 1'b1;
    idx = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.px_valid) begin
        checkOutput("resume_px_x", 32'(bus.px_x), 32'(idx));
        checkOutput("resume_px_data", 32'(bus.px_data), 32'(expand(memWord(expAddr[idx % SW]))));
        checkOutput("resume_done", 32'(line_done), 32'(idx == SW - 1));
        done = line_done;
        idx++;
      end
      @(posedge clk); #1;
    end
    checkOutput("resume_count", 32'(idx), 32'(SW));
    checkOutput("resume_finished", 32'(done), 32'd1);

    // Held GPU write during FETCH: one grant every MAX_VGA_RUN+1 cycles.
    applyStimulus(9'd4, 10'd0, 10'd320);
    bus.gpu_req = 1'b1; bus.gpu_we = 1'b1; bus.gpu_addr = 19'h01234; bus.gpu_wdata = 16'hBEEF;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk);
      checkOutput("guard_gnt", 32'(bus.gpu_gnt), 32'(c % 9 == 0));
      if (c % 9 == 0) begin
        checkOutput("guard_we_n", 32'(sram_we_n), 32'd0);
        checkOutput("guard_oe_n", 32'(sram_oe_n), 32'd1);
        checkOutput("guard_dq_out", 32'(sram_dq_out), 32'hBEEF);
        checkOutput("guard_addr", 32'(sram_addr), 32'h01234);
      end else begin
        checkOutput("guard_fetch_oe", 32'(sram_oe_n), 32'd0);
      end
      @(posedge clk); #1;
    end
    bus.gpu_req = 1'b0; bus.gpu_we = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      done = line_done;
      @(posedge clk); #1;
    end
    checkOutput("guard_line_done", 32'(done), 32'd1);

    // Overrun request mid-line is ignored.
    applyStimulus(9'd2, 10'd0, 10'd320);
    runLine(10);

    // Colour expansion, then asynchronous reset mid-line.
    forceEn = 1'b1; forceWord = 16'h7FFF; bus.px_ready = 1'b0;
    applyStimulus(9'd6, 10'd0, 10'd320);
    @(posedge clk); #1;
    forceWord = 16'h0421;
    @(posedge clk); #1;
    bus.px_ready = 1'b1;
    @(negedge clk);
    checkOutput("colour_7fff", 32'(bus.px_data), 32'hFFFFFF);
    checkOutput("colour_x0", 32'(bus.px_x), 32'd0);
    @(posedge clk); #1;
    bus.px_ready = 1'b0;
    @(negedge clk);
    checkOutput("colour_0421", 32'(bus.px_data), 32'h080808);
    checkOutput("colour_x1", 32'(bus.px_x), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    forceEn = 1'b0;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_valid", 32'(bus.px_valid), 32'd0);
    checkOutput("mid_rst_px_data", 32'(bus.px_data), 32'd0);
    checkOutput("mid_rst_px_x", 32'(bus.px_x), 32'd0);
    checkOutput("mid_rst_oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("mid_rst_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("mid_rst_addr", 32'(sram_addr), 32'd0);
    checkOutput("mid_rst_dq_out", 32'(sram_dq_out), 32'd0);
    checkOutput("mid_rst_done", 32'(line_done), 32'd0);
    bus.gpu_req = 1'b1; bus.gpu_addr = 19'h00020;
    #1;
    checkOutput("mid_rst_gnt", 32'(bus.gpu_gnt), 32'd1);
    bus.gpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.px_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("post_rst_done", 32'(line_done), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_valid", 32'(bus.px_valid), 32'd0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
